// File: rtl/ad_capture_sequencer.sv
// Burst-gated ADC capture sequencer: after a start it waits a delay, then gates the ADC for
// a number of equal bursts separated by gaps, forwarding each gated sample one cycle later.
module ad_capture_sequencer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_20b,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              start,
  input  logic [15:0]       cfg_delay,
  input  logic [9:0]        cfg_burst_len,
  input  logic [7:0]        cfg_gap,
  input  logic [7:0]        cfg_bursts,
  input  logic [DATA_W-1:0] ad_data,
  output logic              ad_gate,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_last,
  output logic [7:0]        burst_idx,
  output logic              busy,
  output logic              done,
  output logic              err_unlock
);

  typedef enum logic [2:0] {StIdle, StDelay, StBurst, StGap, StDone} state_e;

  state_e state_q, state_d;

  logic [15:0] delay_q;
  logic [9:0]  len_q;
  logic [7:0]  gap_q;
  logic [7:0]  bursts_q;

  logic [15:0] delay_cnt_q;
  logic [9:0]  len_cnt_q;
  logic [7:0]  gap_cnt_q;
  logic [7:0]  burst_idx_q;

  logic              gate_q, gate_d;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept, abort, empty_cfg, last_beat, last_burst, delay_end, gap_end;

  assign accept     = (state_q == StIdle) && start && pll_locked;
  assign abort      = (state_q != StIdle) && !pll_locked;
  assign empty_cfg  = (cfg_burst_len == 10'd0) || (cfg_bursts == 8'd0);
  assign last_beat  = (len_cnt_q == len_q - 10'd1);
  assign last_burst = (burst_idx_q == bursts_q - 8'd1);
  assign delay_end  = (delay_cnt_q == delay_q - 16'd1);
  assign gap_end    = (gap_cnt_q == gap_q - 8'd1);

  always_ff @(posedge clk_20b) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (empty_cfg)                state_d = StDone;
            else if (cfg_delay == 16'd0)  state_d = StBurst;
            else                          state_d = StDelay;
          end
        end
        StDelay: if (delay_end) state_d = StBurst;
        StBurst: begin
          if (last_beat) begin
            if (last_burst)          state_d = StDone;
            else if (gap_q == 8'd0)  state_d = StBurst;
            else                     state_d = StGap;
          end
        end
        StGap:   if (gap_end) state_d = StBurst;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_comb begin
    gate_d = (state_d == StBurst);
    last_d = (state_q == StBurst) && last_beat && last_burst && !abort;
    done_d = (state_d == StDone);
    err_d  = abort;
  end

  always_ff @(posedge clk_20b) begin
    if (rst) begin
      delay_q     <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      bursts_q    <= '0;
      delay_cnt_q <= '0;
      len_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      burst_idx_q <= '0;
    end else begin
      if (accept) begin
        delay_q     <= cfg_delay;
        len_q       <= cfg_burst_len;
        gap_q       <= cfg_gap;
        bursts_q    <= cfg_bursts;
        burst_idx_q <= '0;
      end else if (state_q == StBurst && last_beat &&
                   (state_d == StGap || state_d == StBurst)) begin
        burst_idx_q <= burst_idx_q + 8'd1;
      end
      delay_cnt_q <= (state_q == StDelay && state_d == StDelay) ? delay_cnt_q + 16'd1 : '0;
      len_cnt_q   <= (state_q == StBurst && state_d == StBurst && !last_beat) ?
                     len_cnt_q + 10'd1 : '0;
      gap_cnt_q   <= (state_q == StGap && state_d == StGap) ? gap_cnt_q + 8'd1 : '0;
    end
  end

  // Gate high in cycle N means the ADC word of cycle N is captured at the end of N.
  always_ff @(posedge clk_20b) begin
    if (rst) begin
      gate_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      valid_q <= gate_q;
      if (gate_q) data_q <= ad_data;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ad_gate      = gate_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign sample_last  = last_q;
  assign burst_idx    = burst_idx_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err_unlock   = err_q;

endmodule
